// File: rtl/alu_pkg.sv
// Shared constants and types for the multicycle ALU-op sequencer.
// Opcode values, ALU operation codes, FSM states and instruction classes.
package alu_pkg;

  localparam int unsigned OpcBne   = 0;
  localparam int unsigned OpcBeq   = 1;
  localparam int unsigned OpcBgz   = 2;
  localparam int unsigned OpcBlz   = 3;
  localparam int unsigned OpcAdi   = 4;
  localparam int unsigned OpcOri   = 5;
  localparam int unsigned OpcLhi   = 6;
  localparam int unsigned OpcLwd   = 7;
  localparam int unsigned OpcSwd   = 8;
  localparam int unsigned OpcRtype = 15;

  // Largest funct value that maps straight onto an ALU operation.
  localparam int unsigned MaxRFunct = 7;

  localparam logic [3:0] AluAdd = 4'd0;
  localparam logic [3:0] AluAdi = 4'd8;
  localparam logic [3:0] AluOri = 4'd9;
  localparam logic [3:0] AluLhi = 4'd10;
  localparam logic [3:0] AluMem = 4'd11;
  localparam logic [3:0] AluBne = 4'd12;
  localparam logic [3:0] AluBeq = 4'd13;
  localparam logic [3:0] AluBgz = 4'd14;
  localparam logic [3:0] AluBlz = 4'd15;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StExec,
    StMem,
    StWb,
    StBrTgt
  } state_e;

  typedef enum logic [2:0] {
    ClsAlu,
    ClsLoad,
    ClsStore,
    ClsBranch,
    ClsOther
  } inst_class_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of (opcode, funct) into an ALU operation code and
// an instruction class that steers the sequencer.
module alu_op_decode
  import alu_pkg::*;
#(
  parameter int unsigned OPW    = 4,
  parameter int unsigned FUNCTW = 6
) (
  input  logic [OPW-1:0]    opcode,
  input  logic [FUNCTW-1:0] funct,
  output logic [3:0]        alu_ctrl,
  output inst_class_e       inst_class
);

  always_comb begin
    alu_ctrl   = AluAdd;
    inst_class = ClsOther;
    if (opcode == OPW'(OpcRtype)) begin
      if (funct <= FUNCTW'(MaxRFunct)) begin
        alu_ctrl   = funct[3:0];
        inst_class = ClsAlu;
      end
    end else if (opcode == OPW'(OpcAdi)) begin
      alu_ctrl   = AluAdi;
      inst_class = ClsAlu;
    end else if (opcode == OPW'(OpcOri)) begin
      alu_ctrl   = AluOri;
      inst_class = ClsAlu;
    end else if (opcode == OPW'(OpcLhi)) begin
      alu_ctrl   = AluLhi;
      inst_class = ClsAlu;
    end else if (opcode == OPW'(OpcLwd)) begin
      alu_ctrl   = AluMem;
      inst_class = ClsLoad;
    end else if (opcode == OPW'(OpcSwd)) begin
      alu_ctrl   = AluMem;
      inst_class = ClsStore;
    end else if (opcode == OPW'(OpcBne)) begin
      alu_ctrl   = AluBne;
      inst_class = ClsBranch;
    end else if (opcode == OPW'(OpcBeq)) begin
      alu_ctrl   = AluBeq;
      inst_class = ClsBranch;
    end else if (opcode == OPW'(OpcBgz)) begin
      alu_ctrl   = AluBgz;
      inst_class = ClsBranch;
    end else if (opcode == OPW'(OpcBlz)) begin
      alu_ctrl   = AluBlz;
      inst_class = ClsBranch;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multicycle control sequencer: walks one accepted instruction through
// fetch, execute, memory and write-back, and counts retired instructions.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned OPW       = 4,
  parameter int unsigned FUNCTW    = 6,
  parameter int unsigned CNT_W     = WORD_SIZE
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              inst_valid,
  output logic              inst_ready,
  input  logic [OPW-1:0]    opcode,
  input  logic [FUNCTW-1:0] funct,
  input  logic              mem_ack,
  output logic [3:0]        alu_ctrl,
  output logic              pc_write,
  output logic              mem_req,
  output logic              mem_write,
  output logic              reg_write,
  output logic              done,
  output logic [CNT_W-1:0]  retired
);

  state_e            state_q, state_d;
  logic [OPW-1:0]    opcode_q;
  logic [FUNCTW-1:0] funct_q;
  logic [CNT_W-1:0]  retired_q;
  logic [3:0]        dec_ctrl;
  inst_class_e       dec_class;
  logic              accept;

  assign accept  = inst_valid & inst_ready;
  assign retired = retired_q;

  alu_op_decode #(
    .OPW    (OPW),
    .FUNCTW (FUNCTW)
  ) u_decode (
    .opcode     (opcode_q),
    .funct      (funct_q),
    .alu_ctrl   (dec_ctrl),
    .inst_class (dec_class)
  );

  always_comb begin
    state_d    = state_q;
    inst_ready = 1'b0;
    alu_ctrl   = AluAdd;
    pc_write   = 1'b0;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      StIdle: begin
        inst_ready = 1'b1;
        if (inst_valid) state_d = StFetch;
      end
      StFetch: begin
        pc_write = 1'b1;
        if (dec_class == ClsOther) begin
          done    = 1'b1;
          state_d = StIdle;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        alu_ctrl = dec_ctrl;
        unique case (dec_class)
          ClsAlu:             state_d = StWb;
          ClsLoad, ClsStore:  state_d = StMem;
          ClsBranch:          state_d = StBrTgt;
          default:            state_d = StIdle;
        endcase
      end
      StMem: begin
        mem_req   = 1'b1;
        mem_write = (dec_class == ClsStore);
        if (mem_ack) begin
          // A store finishes in the very MEM cycle that sees the ack.
          if (dec_class == ClsStore) begin
            done    = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StWb;
          end
        end
      end
      StWb: begin
        reg_write = 1'b1;
        done      = 1'b1;
        state_d   = StIdle;
      end
      StBrTgt: begin
        pc_write = 1'b1;
        done     = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      opcode_q  <= '0;
      funct_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        opcode_q <= opcode;
        funct_q  <= funct;
      end
      if (done) retired_q <= retired_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: per-cycle control outputs for each
// instruction class, reset during a memory wait and counter wrap.
module tb_alu_op_sequencer;

  logic       clk;
  logic       reset_n;
  logic       inst_valid;
  logic       inst_ready;
  logic [3:0] opcode;
  logic [5:0] funct;
  logic       mem_ack;
  logic [3:0] alu_ctrl;
  logic       pc_write;
  logic       mem_req;
  logic       mem_write;
  logic       reg_write;
  logic       done;
  logic [3:0] retired;

  int n_checks = 0;
  int n_pass   = 0;

  alu_op_sequencer #(
    .WORD_SIZE (16),
    .OPW       (4),
    .FUNCTW    (6),
    .CNT_W     (4)
  ) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .opcode     (opcode),
    .funct      (funct),
    .mem_ack    (mem_ack),
    .alu_ctrl   (alu_ctrl),
    .pc_write   (pc_write),
    .mem_req    (mem_req),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .done       (done),
    .retired    (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance past the next rising edge; outputs then reflect the new cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction and let it be accepted at the next edge (edge 0).
  task automatic issue(input logic [3:0] op, input logic [5:0] fn);
    opcode     = op;
    funct      = fn;
    inst_valid = 1'b1;
    step();
    inst_valid = 1'b0;
    opcode     = 4'd9;
    funct      = 6'd0;
  endtask

  initial begin
    reset_n    = 1'b0;
    inst_valid = 1'b0;
    opcode     = 4'd0;
    funct      = 6'd0;
    mem_ack    = 1'b0;
    #23;
    check_eq("rst_ready", inst_ready, 1);
    check_eq("rst_alu", alu_ctrl, 0);
    check_eq("rst_ctl", {pc_write, mem_req, mem_write, reg_write, done}, 0);
    check_eq("rst_retired", retired, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // ADI: FETCH, EXEC (8), WB
    issue(4'd4, 6'd0);
    check_eq("adi_fetch", {alu_ctrl, pc_write, inst_ready, done}, {4'd0, 1'b1, 1'b0, 1'b0});
    step();
    check_eq("adi_exec", {alu_ctrl, pc_write, reg_write, done}, {4'd8, 3'b000});
    step();
    check_eq("adi_wb", {reg_write, done, pc_write}, 3'b110);
    step();
    check_eq("adi_idle", {inst_ready, alu_ctrl}, {1'b1, 4'd0});
    check_eq("adi_retired", retired, 1);

    // R-type funct 6; the changed input opcode must not disturb the latched one
    issue(4'd15, 6'd6);
    check_eq("r6_fetch_done", done, 0);
    step();
    check_eq("r6_exec", alu_ctrl, 6);
    step();
    check_eq("r6_wb", {reg_write, done}, 2'b11);
    step();

    // R-type funct 25 is OTHER: done in FETCH, no EXEC
    issue(4'd15, 6'd25);
    check_eq("r25_fetch", {pc_write, done, alu_ctrl}, {2'b11, 4'd0});
    step();
    check_eq("r25_idle", inst_ready, 1);
    check_eq("r25_retired", retired, 3);

    // LWD with ack arriving in the third MEM cycle: done at cycle 6
    issue(4'd7, 6'd0);
    step();
    check_eq("lwd_exec", alu_ctrl, 11);
    step();
    check_eq("lwd_mem1", {mem_req, mem_write, done}, 3'b100);
    step();
    check_eq("lwd_mem2", {mem_req, mem_write, done}, 3'b100);
    step();
    check_eq("lwd_mem3", {mem_req, mem_write, done}, 3'b100);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check_eq("lwd_wb", {mem_req, reg_write, done}, 3'b011);
    step();
    check_eq("lwd_retired", retired, 4);

    // SWD with ack already high: single MEM cycle carries done
    mem_ack = 1'b1;
    issue(4'd8, 6'd0);
    check_eq("swd_fetch_rw", reg_write, 0);
    step();
    check_eq("swd_exec", {alu_ctrl, reg_write}, {4'd11, 1'b0});
    step();
    check_eq("swd_mem", {mem_req, mem_write, done, reg_write}, 4'b1110);
    step();
    mem_ack = 1'b0;
    check_eq("swd_idle", {inst_ready, reg_write, mem_req}, 3'b100);
    check_eq("swd_retired", retired, 5);

    // BEQ: EXEC 13 then BRTGT
    issue(4'd1, 6'd0);
    step();
    check_eq("beq_exec", {alu_ctrl, pc_write}, {4'd13, 1'b0});
    step();
    check_eq("beq_brtgt", {alu_ctrl, pc_write, done, reg_write}, {4'd0, 3'b110});
    step();
    check_eq("beq_retired", retired, 6);

    // Reset asserted while a load waits in MEM
    issue(4'd7, 6'd0);
    step();
    step();
    check_eq("rmem_pre", mem_req, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("rmem_ctl", {mem_req, mem_write, reg_write, pc_write, done}, 0);
    check_eq("rmem_ready", inst_ready, 1);
    check_eq("rmem_retired", retired, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // 16 back-to-back OTHER instructions with inst_valid held high
    opcode     = 4'd9;
    funct      = 6'd0;
    inst_valid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      step();
    end
    check_eq("wrap_15", retired, 15);
    step();
    check_eq("wrap_fetch_done", done, 1);
    step();
    inst_valid = 1'b0;
    check_eq("wrap_0", retired, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
